// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product in WIDTH cycles.
// Optional two's-complement mode enabled by defining SEQ_MULT_SIGNED_EN (adds signed_op port).
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 signed_op,
`endif
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one shift-add step per cycle
  // DONE  | product valid, done pulses for one cycle
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mplier, mcand;
  logic [WIDTH-1:0]   a_in, b_in;
  logic [2*WIDTH-1:0] acc, acc_step, result;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      count;
  logic               accept, last;
`ifdef SEQ_MULT_SIGNED_EN
  logic               negate;
`endif

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (count == CW'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed mode iterates on magnitudes; the sign is reapplied on the final step.
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    a_in = (signed_op && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    b_in = (signed_op && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
`else
    a_in = multiplier;
    b_in = multiplicand;
`endif
  end

  // Carry out of the upper-half add lands in the MSB after the right shift.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
`ifdef SEQ_MULT_SIGNED_EN
    result   = negate ? -acc_step : acc_step;
`else
    result   = acc_step;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      negate  <= 1'b0;
`endif
    end else if (accept) begin
      mplier  <= a_in;
      mcand   <= b_in;
      acc     <= '0;
      count   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      negate  <= signed_op && (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
`endif
    end else if (state == RUN) begin
      acc     <= acc_step;
      mplier  <= mplier >> 1;
      count   <= count + 1'b1;
      if (last) product <= result;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8): stimulus pushes expected product and
// done cycle; a negedge monitor pops and compares whenever done pulses.
module tb_seq_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_op = 1'b0;
  logic [W-1:0]   multiplier = '0;
  logic [W-1:0]   multiplicand = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
    string          name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_op    (signed_op),
`endif
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=done product=0x%0h required=no done", product);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_product"}, 32'(product), 32'(e.prod));
        check({e.name, "_latency"}, cyc, e.due);
        check({e.name, "_busy_low"}, 32'(busy), 32'd0);
      end
    end
  end

  // Drive start with operands at the current point (just after a negedge); accepted on next posedge.
  task automatic set_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [2*W-1:0] exp_prod, input string name);
    exp_t e;
    start        = 1'b1;
    multiplier   = a;
    multiplicand = b;
    signed_op    = s;
    e.prod = exp_prod;
    e.due  = cyc + 1 + W;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] exp_prod, input string name);
    @(negedge clk);
    set_start(a, b, s, exp_prod, name);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual=%0d pending required=0 pending", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic product and fixed latency
    issue(8'd105, 8'd26, 1'b0, 16'h0AAA, "t1_105x26");
    check("t1_busy_running", 32'(busy), 32'd1);
    drain("t1");

    issue(8'd255, 8'd255, 1'b0, 16'hFE01, "t2_255x255");
    drain("t2a");
    issue(8'd0, 8'd200, 1'b0, 16'h0000, "t2_0x200");
    drain("t2b");
    issue(8'd1, 8'd255, 1'b0, 16'h00FF, "t2_1x255");
    drain("t2c");

    // Start while busy is ignored
    issue(8'd10, 8'd12, 1'b0, 16'd120, "t3_10x12");
    @(negedge clk);
    check("t3_busy_before_ignored", 32'(busy), 32'd1);
    start = 1'b1; multiplier = 8'd99; multiplicand = 8'd99;
    @(negedge clk);
    start = 1'b0;
    drain("t3");
    check("t3_product_held", 32'(product), 32'd120);

    // Asynchronous reset mid-run aborts with no done
    issue(8'd50, 8'd50, 1'b0, 16'd0, "t4_aborted");
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'd3, 8'd7, 1'b0, 16'd21, "t4_3x7");
    drain("t4");

    // Back-to-back: start held on the done cycle
    issue(8'd2, 8'd3, 1'b0, 16'd6, "t5_2x3");
    repeat (W) @(negedge clk);
    check("t5_done_cycle", 32'(done), 32'd1);
    set_start(8'd6, 8'd7, 1'b0, 16'd42, "t5_6x7");
    @(negedge clk);
    start = 1'b0;
    check("t5_busy_after_b2b", 32'(busy), 32'd1);
    drain("t5");

`ifdef SEQ_MULT_SIGNED_EN
    issue(8'hFD, 8'd5, 1'b1, 16'hFFF1, "t6_m3x5");
    drain("t6a");
    issue(8'h80, 8'h80, 1'b1, 16'h4000, "t6_m128xm128");
    drain("t6b");
    issue(8'd7, 8'hFE, 1'b1, 16'hFFF2, "t6_7xm2");
    drain("t6c");
    issue(8'h80, 8'h80, 1'b0, 16'h4000, "t6_u128x128");
    drain("t6d");
`else
    issue(8'h80, 8'h80, 1'b0, 16'h4000, "t6_u128x128");
    drain("t6d");
    issue(8'hFD, 8'd5, 1'b0, 16'h04F1, "t6_u253x5");
    drain("t6e");
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier. It is the successor to the team's combinational byte multiplier.
- Computes a WIDTH x WIDTH unsigned product (optionally signed) over WIDTH clock cycles.
- Uses a start/busy/done handshake.
- Sits in the arithmetic circuits library for datapaths that trade latency for area.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH.

Ports:
clk  input  1  system clock, rising edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request: latch operands and begin a multiply
multiplier  input  WIDTH  operand A, sampled only on an accepted start
multiplicand  input  WIDTH  operand B, sampled only on an accepted start
signed_op  input  1  present only when SEQ_MULT_SIGNED_EN is defined; sampled on an accepted start
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse: product is valid
product  output  2*WIDTH  result; held stable from done until the next accepted start

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; product=0; busy=0; done=0; internal accumulator, operand registers and counter cleared. Reset asserted mid-operation aborts the multiply immediately; no done is issued.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(count==WIDTH-1)--> DONE.
  - DONE --start--> RUN (back-to-back accepted).
  - DONE --!start--> IDLE.
- Start acceptance: start is accepted only in IDLE or DONE. Start while busy=1 is ignored; operands are not re-sampled and the result is unaffected.
- On accept (edge k):
  - Latch operands.
  - Clear accumulator.
  - Counter=0.
  - busy=1 from edge k.
  - product retains its old value until completion.
- RUN step (each edge):
  - If the current multiplier LSB=1, add the multiplicand into the upper half of the accumulator, with carry into bit 2*WIDTH.
  - Shift the accumulator and multiplier right by 1.
  - Counter+1.
- Completion: after exactly WIDTH RUN cycles, at edge k+WIDTH:
  - product = final accumulator.
  - done=1 for one cycle.
  - busy=0.
  - Latency start-to-done = WIDTH cycles.
- Width rule: the full 2*WIDTH product is always exact; no overflow is possible and no truncation occurs.
- Zero operands still take the full WIDTH cycles; latency is data-independent.
- done and busy are never high in the same cycle.

Optional Feature:
Macro: SEQ_MULT_SIGNED_EN.

Defined:
- The signed_op port exists.
- When signed_op=1 at accept:
  - Operands are treated as two's complement.
  - Magnitudes are taken before iteration.
  - The result is negated at completion if the operand signs differ.
- Latency is unchanged (WIDTH cycles).
- The most-negative x most-negative case yields the exact positive product.
- When signed_op=0, behaviour is identical to unsigned.

Undefined:
- No signed_op port.
- Unsigned only.

Test Plan:
1. WIDTH=8, reset then start with multiplier=105, multiplicand=26 -> busy high for 8 cycles, then done pulses one cycle with product=2730 (0x0AAA).
2. WIDTH=8, operands 255 x 255, then 0 x 200 -> product=65025 (0xFE01), then 0; each done arrives exactly 8 cycles after its start.
3. Start 10 x 12; pulse start with 99 x 99 at cycle 3 of RUN -> second start ignored; product=120 at done.
4. Start 50 x 50; assert rst at cycle 4 -> busy=0, done=0, product=0 immediately (asynchronous); no done afterwards. After release, 3 x 7 -> product=21.
5. Back-to-back: start held high on the done cycle with 6 x 7 following 2 x 3 -> product=6 at first done, then 42 exactly 8 cycles later.
6. SEQ_MULT_SIGNED_EN, WIDTH=8, signed_op=1:
   - -3 x 5 -> product=0xFFF1 (-15).
   - -128 x -128 -> product=0x4000 (16384).
   - signed_op=0, 0x80 x 0x80 -> product=0x4000.
